// File: rtl/boot_link_pkg.sv
// Definitions shared by both ends of the serial boot-load link (sender and receiving loader).
package boot_link_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_STOP_BITS = 1;
  localparam logic        UART_IDLE_LINE = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCapture,
    StLoad,
    StWaitTx,
    StFinish
  } sender_state_e;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } uart_tx_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first. tx_ready is also high in the last stop cycle so a new
// frame can be loaded back-to-back with no idle gap.
module uart_tx
  import boot_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ce,
  input  logic       i_tx_load,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_tx
);

  localparam int unsigned STOP_CLKS = CLKS_PER_BIT * UART_STOP_BITS;
  localparam int unsigned CYC_W     = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;
  localparam int unsigned BIT_W     = $clog2(UART_DATA_BITS);

  uart_tx_state_e   r_state, w_state_d;
  logic [CYC_W-1:0] r_cyc, w_cyc_d;
  logic [BIT_W-1:0] r_bit, w_bit_d;
  logic [7:0]       r_data, w_data_d;
  logic             r_tx, w_tx_d;
  logic             w_bit_end, w_stop_end;

  assign w_bit_end  = (r_cyc == CYC_W'(CLKS_PER_BIT - 1));
  assign w_stop_end = (r_cyc == CYC_W'(STOP_CLKS - 1));
  assign o_tx_ready = (r_state == TxIdle) || ((r_state == TxStop) && w_stop_end);
  assign o_tx       = r_tx;

  always_comb begin
    w_state_d = r_state;
    w_cyc_d   = r_cyc + CYC_W'(1);
    w_bit_d   = r_bit;
    w_data_d  = r_data;
    w_tx_d    = UART_IDLE_LINE;
    unique case (r_state)
      TxIdle: w_cyc_d = '0;
      TxStart: begin
        if (w_bit_end) begin
          w_state_d = TxData;
          w_cyc_d   = '0;
          w_bit_d   = '0;
        end
      end
      TxData: begin
        if (w_bit_end) begin
          w_cyc_d = '0;
          if (r_bit == BIT_W'(UART_DATA_BITS - 1)) begin
            w_state_d = TxStop;
          end else begin
            w_bit_d = r_bit + BIT_W'(1);
          end
        end
      end
      TxStop: begin
        if (w_stop_end) begin
          w_state_d = TxIdle;
          w_cyc_d   = '0;
        end
      end
      default: w_state_d = TxIdle;
    endcase
    if (i_tx_load && o_tx_ready) begin
      w_state_d = TxStart;
      w_cyc_d   = '0;
      w_bit_d   = '0;
      w_data_d  = i_tx_data;
    end
    // Line level is registered from the next state so tx is glitch-free.
    case (w_state_d)
      TxStart: w_tx_d = 1'b0;
      TxData:  w_tx_d = w_data_d[w_bit_d];
      default: w_tx_d = UART_IDLE_LINE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= TxIdle;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_data  <= '0;
      r_tx    <= UART_IDLE_LINE;
    end else if (i_ce) begin
      r_state <= w_state_d;
      r_cyc   <= w_cyc_d;
      r_bit   <= w_bit_d;
      r_data  <= w_data_d;
      r_tx    <= w_tx_d;
    end
  end

endmodule

// File: rtl/boot_sender.sv
// Boot-image sender: streams `length` bytes from a synchronous memory as back-to-back 8N1 frames.
// Define BOOT_SENDER_CHECKSUM_EN to append one modulo-256 sum frame after the data bytes.
module boot_sender
  import boot_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ce,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_length,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_re,
  input  logic [7:0]        i_mem_data,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_done
);

  // Holds 2^ADDR_W data bytes plus an optional checksum frame.
  localparam int unsigned CNT_W = ADDR_W + 2;

  sender_state_e    r_state, w_state_d;
  logic [CNT_W-1:0] r_count, w_count_d;
  logic [CNT_W-1:0] r_total, w_total_d, w_total_in;
  logic [7:0]       r_buf, w_buf_d, w_capture;
  logic             r_full, w_full_d;
  logic             w_is_chk, w_more, w_load_ok;
  logic             w_tx_load, w_tx_ready;

`ifdef BOOT_SENDER_CHECKSUM_EN
  logic [7:0] r_sum, w_sum_d;

  assign w_total_in = CNT_W'(i_length) + CNT_W'(1);
  assign w_is_chk   = (r_count == r_total - CNT_W'(1));
  assign w_capture  = w_is_chk ? r_sum : i_mem_data;

  always_comb begin
    w_sum_d = r_sum;
    if ((r_state == StIdle) && i_start) begin
      w_sum_d = '0;
    end else if ((r_state == StCapture) && !w_is_chk) begin
      w_sum_d = r_sum + i_mem_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sum <= '0;
    end else if (i_ce) begin
      r_sum <= w_sum_d;
    end
  end
`else
  assign w_total_in = CNT_W'(i_length);
  assign w_is_chk   = 1'b0;
  assign w_capture  = i_mem_data;
`endif

  assign w_more     = (r_count + CNT_W'(1)) < r_total;
  assign w_load_ok  = w_tx_ready && ((r_state == StLoad) || ((r_state == StWaitTx) && r_full));
  assign o_mem_addr = r_count[ADDR_W-1:0];
  assign o_busy     = (r_state != StIdle) && (r_state != StFinish);
  assign o_done     = (r_state == StFinish);

  always_comb begin
    w_state_d = r_state;
    w_count_d = r_count;
    w_total_d = r_total;
    w_buf_d   = r_buf;
    w_full_d  = r_full;
    w_tx_load = 1'b0;
    o_mem_re  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_total_d = w_total_in;
          w_count_d = '0;
          w_full_d  = 1'b0;
          w_state_d = (w_total_in != '0) ? StFetch : StFinish;
        end
      end
      StFetch: begin
        o_mem_re  = !w_is_chk;
        w_state_d = StCapture;
      end
      StCapture: begin
        w_buf_d   = w_capture;
        w_full_d  = 1'b1;
        w_state_d = StLoad;
      end
      // Transmitter still busy: park with the buffer full until it frees up.
      StLoad: w_state_d = StWaitTx;
      StWaitTx: begin
        if (!r_full && w_tx_ready && (r_count == r_total)) w_state_d = StFinish;
      end
      StFinish: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
    if (w_load_ok) begin
      w_tx_load = 1'b1;
      w_full_d  = 1'b0;
      w_count_d = r_count + CNT_W'(1);
      w_state_d = w_more ? StFetch : StWaitTx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_count <= '0;
      r_total <= '0;
      r_buf   <= '0;
      r_full  <= 1'b0;
    end else if (i_ce) begin
      r_state <= w_state_d;
      r_count <= w_count_d;
      r_total <= w_total_d;
      r_buf   <= w_buf_d;
      r_full  <= w_full_d;
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_ce      (i_ce),
    .i_tx_load (w_tx_load),
    .i_tx_data (r_buf),
    .o_tx_ready(w_tx_ready),
    .o_tx      (o_tx)
  );

endmodule

// File: doc/boot_sender.md
Name: boot_sender

Overview:
- UART boot-image transmitter: the host/initiator end of the serial boot-load link.
- On a start pulse it reads `length` bytes from a synchronous memory, starting at address 0.
- Each byte goes out as an 8N1 UART frame on `tx`, LSB first.
- Lives beside the receiving loader so one chip can program another, or loop back for self-test.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200); legal range ≥2.
- ADDR_W, 8, memory address width; maximum image size is 2^ADDR_W bytes.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous reset, active low
- ce  input  1  clock enable; when 0, all state holds
- start  input  1  single-cycle request to begin transfer; sampled only in IDLE
- length  input  ADDR_W+1  number of bytes to send; captured on accepted start
- mem_addr  output  ADDR_W  memory read address
- mem_re  output  1  memory read strobe; read data valid the cycle after
- mem_data  input  8  memory read data
- tx  output  1  UART line, idle high
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse at end of transfer

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst_n` is synchronous and active-low.
- Reset values:
  - tx=1, busy=0, done=0, mem_re=0, mem_addr=0.
  - Internal counters 0; FSM in IDLE; sub-module idle.
- ce=0: no register updates, outputs hold; bit timing stretches accordingly.
- Top FSM states: IDLE, FETCH, CAPTURE, LOAD, WAIT_TX, FINISH.
- IDLE:
  - start=1 and length≠0: latch length, clear byte count, go to FETCH, busy=1 next cycle.
  - start=1 and length=0: go to FINISH; tx never leaves 1.
- FETCH: mem_re=1 for one cycle with mem_addr=byte count; go to CAPTURE.
- CAPTURE: register mem_data into the byte buffer; go to LOAD.
- LOAD: assert tx_load when tx_ready=1; increment byte count.
  - More bytes remain: go to FETCH (prefetch overlaps the current frame), then WAIT_TX once the buffer is full.
  - Else: go to WAIT_TX.
- WAIT_TX:
  - Buffer full: hand off at the next tx_ready.
  - All bytes loaded and sub-module idle: go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0 in the same cycle; go to IDLE.
- Frames are back-to-back: the next start bit begins the cycle after the previous stop bit ends, with no idle gap.
- start while busy is ignored. Changes to length while busy are ignored.
- length=2^ADDR_W: mem_addr runs 0..2^ADDR_W-1 with no wrap.
- Reset mid-frame: tx=1 on the next enabled edge and the transfer is aborted; no done pulse.
- uart_tx sub-module:
  - States IDLE, START, DATA, STOP. Bit counter 0..7, cycle counter 0..CLKS_PER_BIT-1.
  - tx_ready=1 in IDLE and in the last cycle of STOP.
  - tx_load accepted when tx_ready=1; START begins the next cycle.
  - tx=0 in START, data bit n in DATA, tx=1 in STOP.
  - Frame length is 10*CLKS_PER_BIT cycles.

Optional Feature:
- Macro: BOOT_SENDER_CHECKSUM_EN.
- Defined:
  - After the last data byte, send one extra frame carrying the 8-bit modulo-256 sum of all data bytes.
  - Sum resets on accepted start. done follows the checksum frame's stop bit.
  - length=0 sends a single 0x00 checksum frame.
- Undefined: no checksum logic; exactly `length` frames.

Decomposition:
- Package boot_link_pkg:
  - FSM state enums for top and uart_tx.
  - UART_DATA_BITS=8, UART_STOP_BITS=1.
  - Idle-line constant 1'b1.
- Shared with the receiving loader.
- One sub-module: uart_tx (parameter CLKS_PER_BIT; ports clk, rst_n, ce, tx_load, tx_data[7:0], tx_ready, tx).

Test Plan (CLKS_PER_BIT=4, ADDR_W=4):
- Reset asserted 3 cycles mid-run -> tx=1, busy=0, done=0, mem_re=0, mem_addr=0 after the first edge.
- mem[0]=0x55, start with length=1 -> mem_re at addr 0; tx shows 0 then bits 1,0,1,0,1,0,1,0, then 1, each 4 cycles; done pulses once after the stop bit.
- mem[0..2]=0xA5,0x01,0xFF, length=3 -> addresses 0,1,2 in order; three frames totalling 120 cycles with no idle gap; done once.
- length=0 -> done pulse 2 cycles after start; tx constantly 1; mem_re never asserted.
- start re-pulsed mid-transfer, and ce held low for 10 cycles mid-frame -> second start ignored; tx bit widths extended by exactly 10 cycles; data unchanged.
- BOOT_SENDER_CHECKSUM_EN defined, bytes 0x80,0x90 -> third frame carries 0x10; done only after that frame.
